// File: rtl/video_scroll.sv
// Scrolling LCD-on-VGA renderer: VGA timing, per-row 41-byte VRAM line fetch in hblank, 2bpp palette decode.
// RGB is registered one clk behind hcount/vcount; no backpressure, VRAM answers one clk after addr.
module video_scroll #(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 32,
  parameter int          H_SYNC     = 48,
  parameter int          H_TOTAL    = 800,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 1,
  parameter int          V_SYNC     = 3,
  parameter int          V_TOTAL    = 510,
  parameter int          SCALE      = 2,
  parameter int          X_BORDER   = 80,
  parameter int          Y_BORDER   = 40,
  parameter int          ROW_STRIDE = 48,
  parameter int          ROW_WRAP   = 170,
  parameter logic [23:0] PAL0       = 24'h87BA6B,
  parameter logic [23:0] PAL1       = 24'h6BA378,
  parameter logic [23:0] PAL2       = 24'h386B82,
  parameter logic [23:0] PAL3       = 24'h384052
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [7:0]  lcd_xsize,
  input  logic [7:0]  lcd_ysize,
  input  logic [7:0]  lcd_xscroll,
  input  logic [7:0]  lcd_yscroll,
  output logic [12:0] addr,
  input  logic [7:0]  data,
  output logic        ce_pxl,
  output logic        fetch_busy,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [5:0] LAST_IDX = 6'd40;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [12:0]   addr_q, addr_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    xs_q, xs_d;
  logic [7:0]    ys_q, ys_d;
  logic          wr_vld_q, wr_vld_d;
  logic [5:0]    wr_idx_q, wr_idx_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [7:0]    line_buf_q [0:40];

  logic          h_last, frame_start, in_win, row_start;
  logic [15:0]   hpix, vpix, lx, ly, nv, nvpix, nly;
  logic [7:0]    xsize_c, ysize_c, s, pix_byte, next_row;
  logic [5:0]    rd_idx;
  logic [1:0]    pix_idx;
  logic [23:0]   pal;

  function automatic logic [12:0] calc_addr(input logic [7:0] row, input logic [5:0] col0,
                                            input logic [5:0] i);
    logic [15:0] col;
    // Column wraps inside the row so a scrolled fetch never spills into the next VRAM row.
    col = (16'(col0) + 16'(i)) % 16'(ROW_STRIDE);
    return 13'(16'(row) * 16'(ROW_STRIDE) + col);
  endfunction

  always_comb begin
    h_last      = hcount_q == HW'(H_TOTAL - 1);
    frame_start = (hcount_q == '0) && (vcount_q == '0);
    hcount_d    = h_last ? '0 : hcount_q + HW'(1);
    vcount_d    = vcount_q;
    if (h_last) begin
      vcount_d = (vcount_q == VW'(V_TOTAL - 1)) ? '0 : vcount_q + VW'(1);
    end
    xs_d = frame_start ? lcd_xscroll : xs_q;
    ys_d = frame_start ? lcd_yscroll : ys_q;
  end

  always_comb begin
    hsync  = !((hcount_q >= HW'(H_ACTIVE + H_FP)) && (hcount_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync  = !((vcount_q >= VW'(V_ACTIVE + V_FP)) && (vcount_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    hblank = hcount_q >= HW'(H_ACTIVE);
    vblank = vcount_q >= VW'(V_ACTIVE);
    ce_pxl = (16'(hcount_q) % 16'(SCALE)) == 16'(SCALE - 1);
  end

  always_comb begin
    xsize_c = (lcd_xsize > 8'd160) ? 8'd160 : lcd_xsize;
    ysize_c = (lcd_ysize > 8'd160) ? 8'd160 : lcd_ysize;
    hpix    = 16'(hcount_q) / 16'(SCALE);
    vpix    = 16'(vcount_q) / 16'(SCALE);
    lx      = hpix - 16'(X_BORDER);
    ly      = vpix - 16'(Y_BORDER);
    in_win  = !hblank && !vblank &&
              (hpix >= 16'(X_BORDER)) && (lx < {8'd0, xsize_c}) &&
              (vpix >= 16'(Y_BORDER)) && (ly < {8'd0, ysize_c});
    // Fine scroll shifts the pixel position into the fetched bytes by xs[1:0].
    s        = 8'(lx) + {6'd0, xs_q[1:0]};
    rd_idx   = in_win ? s[7:2] : 6'd0;
    pix_byte = line_buf_q[rd_idx];
    pix_idx  = 2'(pix_byte >> {s[1:0], 1'b0});
    case (pix_idx)
      2'd0:    pal = PAL0;
      2'd1:    pal = PAL1;
      2'd2:    pal = PAL2;
      default: pal = PAL3;
    endcase
    rgb_d = (ce && in_win) ? pal : 24'd0;
  end

  always_comb begin
    nv        = (vcount_q == VW'(V_TOTAL - 1)) ? 16'd0 : 16'(vcount_q) + 16'd1;
    nvpix     = nv / 16'(SCALE);
    nly       = nvpix - 16'(Y_BORDER);
    row_start = ((nv % 16'(SCALE)) == 16'd0) && (nvpix >= 16'(Y_BORDER)) && (nly < 16'd160);
    next_row  = 8'((16'(ys_q) + nly) % 16'(ROW_WRAP));
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    row_d    = row_q;
    wr_vld_d = 1'b0;
    wr_idx_d = idx_q;
    case (state_q)
      IDLE: begin
        if (ce && (hcount_q == HW'(H_ACTIVE)) && row_start) begin
          state_d = FETCH;
          idx_d   = 6'd0;
          row_d   = next_row;
          addr_d  = calc_addr(next_row, xs_q[7:2], 6'd0);
        end
      end
      FETCH: begin
        // The byte addressed this clk lands on data next clk and is written then.
        wr_vld_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idx_q + 6'd1;
          addr_d = calc_addr(row_q, xs_q[7:2], idx_q + 6'd1);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      state_q  <= IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      row_q    <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      wr_vld_q <= 1'b0;
      wr_idx_q <= '0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      row_q    <= row_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      wr_vld_q <= wr_vld_d;
      wr_idx_q <= wr_idx_d;
      rgb_q    <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_vld_q) begin
      line_buf_q[wr_idx_q] <= data;
    end
  end

  assign addr       = addr_q;
  assign fetch_busy = state_q != IDLE;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];

endmodule

// File: doc/video_scroll.md
VIDEO_SCROLL -- requirements
Module: video_scroll

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  H_ACTIVE 640 visible VGA columns; H_FP 32 front porch; H_SYNC 48 sync width; H_TOTAL 800 cycles per line.
  V_ACTIVE 480 visible lines; V_FP 1; V_SYNC 3; V_TOTAL 510 lines per frame.
  SCALE 2 VGA pixels/lines per LCD pixel (1..4); X_BORDER 80, Y_BORDER 40 border size in LCD pixels.
  ROW_STRIDE 48 VRAM bytes per row; ROW_WRAP 170 VRAM rows before wrap.
  PAL0..PAL3 24'h87BA6B, 24'h6BA378, 24'h386B82, 24'h384052 palette RGB.
REQ-002 SHALL have ports, one per line (name direction width meaning):
  clk in 1 system clock, sole clock.
  reset in 1 synchronous active-high reset.
  ce in 1 display enable; 0 forces black RGB.
  lcd_xsize in 8 visible LCD width (pixels, 0..160).
  lcd_ysize in 8 visible LCD height (rows, 0..160).
  lcd_xscroll in 8 horizontal scroll (pixels).
  lcd_yscroll in 8 vertical scroll (rows).
  addr out 13 VRAM byte address.
  data in 8 VRAM data, valid one cycle after addr.
  ce_pxl out 1 high on the last clk of each SCALE-wide LCD pixel.
  fetch_busy out 1 line-fetch FSM not IDLE.
  hsync, vsync out 1 each, active low.
  hblank, vblank out 1 each, active high.
  red, green, blue out 8 each, registered.

Function
REQ-003 hcount SHALL count 0..H_TOTAL-1 every clk, wrap to 0; vcount SHALL increment on hcount wrap, 0..V_TOTAL-1, wrap to 0.
REQ-004 hsync low iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync low iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; hblank = hcount >= H_ACTIVE; vblank = vcount >= V_ACTIVE; all combinational from counters.
REQ-005 LCD window: lx = hcount/SCALE - X_BORDER, ly = vcount/SCALE - Y_BORDER; inside iff 0 <= lx < min(lcd_xsize,160) and 0 <= ly < min(lcd_ysize,160); outside -> RGB 0.
REQ-006 lcd_xscroll/lcd_yscroll SHALL be latched into xs/ys at hcount==0, vcount==0 only; mid-frame changes take effect next frame.
REQ-007 Line buffer SHALL hold 41 bytes (160 pixels plus fine-scroll spill).
REQ-008 FSM states IDLE, FETCH, DRAIN. IDLE->FETCH at hcount==H_ACTIVE when next line vcount+1 (mod V_TOTAL) is the first VGA line of an LCD row ly in 0..159 and ce==1.
REQ-009 FETCH: issue byte index i=0..40, one per clk; addr = ((ys+ly) mod ROW_WRAP)*ROW_STRIDE + ((xs>>2)+i) mod ROW_STRIDE; after i=40 go DRAIN.
REQ-010 data for index i SHALL be written to buffer[i] the clk after its addr; DRAIN lasts one clk (last write), then IDLE. Fetch total 42 clks, must complete inside hblank (H_TOTAL-H_ACTIVE >= 42).
REQ-011 addr SHALL hold its last value while IDLE.
REQ-012 Pixel decode: s = lx + xs[1:0]; byte = buffer[s>>2]; index = byte[2*s[1:0] +: 2] (LSB-first); RGB = PALindex.
REQ-013 RGB SHALL be registered: one clk latency from hcount/vcount; RGB updated every clk (not only on ce_pxl).
REQ-014 ce low SHALL force RGB 0 and suppress new fetches; a fetch in progress completes.
REQ-015 lcd_xsize/lcd_ysize > 160 SHALL be clamped to 160; value 0 shows full border.
REQ-016 Row wrap: (ys+ly) >= ROW_WRAP wraps to row 0; column wrap within the row, never into the next row.

Reset
REQ-017 reset SHALL set hcount=0, vcount=0, FSM IDLE, addr=0, xs=ys=0, RGB=0, fetch_busy=0; hsync=vsync=1, hblank=vblank=0 after reset; buffer contents undefined.
REQ-018 reset asserted mid-FETCH SHALL abort the fetch in the next clk; no further buffer writes.

Verification
REQ-019 Reset, run one frame: hsync period 800 clks, low 48 clks from hcount 672; vsync low lines 481..483; frame 408000 clks.
REQ-020 VRAM row0 byte0=8'hE4, scroll 0, sizes 160: LCD pixels 0..3 emit PAL0,PAL1,PAL2,PAL3, each 2 VGA pixels wide, starting at hcount 161.
REQ-021 lcd_xscroll=5: row fetch addresses start at 1, and pixel 0 uses bits [3:2] of buffer[0].
REQ-022 lcd_yscroll=169, ly=1: addr row part = 0 (wrap); lcd_xscroll=188: byte index 47 followed by 0.
REQ-023 lcd_xsize=100: lx>=100 black; change lcd_yscroll mid-frame: no effect until next vcount=0.
REQ-024 reset pulsed at FETCH index 20: fetch_busy=0 next clk, counters 0, RGB 0.
